// File: rtl/mult_s4_seq_ctrl.sv
// rtl/mult_s4_seq_ctrl.sv - 4x4 signed/unsigned multiply sequenced over one shared 4x4 unsigned multiplier
// Optional build macro: MULTS4_EARLY_EXIT_EN (skip partial-product phases whose term is zero)

module mult_u4_bits (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  assign p = {4'b0000, a} * {4'b0000, b};
endmodule

module mult_s4_seq_ctrl #(
  parameter int SIGNED = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic       busy,
  output logic       done,
  output logic [7:0] prod
);

  typedef enum logic [2:0] {IDLE, P0, P1, P2, P3, DONE} state_t;

  state_t     state;
  state_t     nxt_phase;
  logic [3:0] xr;
  logic [3:0] yr;
  logic [3:0] ma;
  logic [3:0] mb;
  logic [7:0] m;
  logic [7:0] acc;
  logic [7:0] acc_nxt;
  logic       sub;

  mult_u4_bits u_mult (
    .a (ma),
    .b (mb),
    .p (m)
  );

  // x = -8*x[3] + x[2:0]: cross terms carry one negative weight, the sign*sign term two
  always_comb begin
    ma  = 4'h0;
    mb  = 4'h0;
    sub = 1'b0;
    case (state)
      P0: begin
        ma = {1'b0, xr[2:0]};
        mb = {1'b0, yr[2:0]};
      end
      P1: begin
        ma  = {xr[3], 3'b000};
        mb  = {1'b0, yr[2:0]};
        sub = (SIGNED != 0);
      end
      P2: begin
        ma  = {yr[3], 3'b000};
        mb  = {1'b0, xr[2:0]};
        sub = (SIGNED != 0);
      end
      P3: begin
        ma = {xr[3], 3'b000};
        mb = {yr[3], 3'b000};
      end
      default: begin
        ma  = 4'h0;
        mb  = 4'h0;
        sub = 1'b0;
      end
    endcase
    acc_nxt = sub ? (acc - m) : (acc + m);
  end

  always_comb begin
    nxt_phase = DONE;
`ifdef MULTS4_EARLY_EXIT_EN
    case (state)
      P0:      nxt_phase = xr[3] ? P1 : (yr[3] ? P2 : DONE);
      P1:      nxt_phase = yr[3] ? P2 : DONE;
      P2:      nxt_phase = (xr[3] & yr[3]) ? P3 : DONE;
      default: nxt_phase = DONE;
    endcase
`else
    case (state)
      P0:      nxt_phase = P1;
      P1:      nxt_phase = P2;
      P2:      nxt_phase = P3;
      default: nxt_phase = DONE;
    endcase
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      prod  <= 8'h00;
      acc   <= 8'h00;
      xr    <= 4'h0;
      yr    <= 4'h0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          busy <= start;
          if (start) begin
            xr    <= x;
            yr    <= y;
            acc   <= 8'h00;
            state <= P0;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          acc   <= acc_nxt;
          state <= nxt_phase;
          if (nxt_phase == DONE) begin
            prod <= acc_nxt;
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_s4_seq_ctrl.sv
// tb/tb_mult_s4_seq_ctrl.sv - directed and sweep checks of mult_s4_seq_ctrl, signed and unsigned instances

module tb_mult_s4_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_s, start_u;
  logic [3:0] x, y;
  logic       busy_s, done_s, busy_u, done_u;
  logic [7:0] prod_s, prod_u;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mult_s4_seq_ctrl #(.SIGNED(1)) dut_s (
    .clk(clk), .reset(reset), .start(start_s), .x(x), .y(y),
    .busy(busy_s), .done(done_s), .prod(prod_s)
  );

  mult_s4_seq_ctrl #(.SIGNED(0)) dut_u (
    .clk(clk), .reset(reset), .start(start_u), .x(x), .y(y),
    .busy(busy_u), .done(done_u), .prod(prod_u)
  );

  typedef struct {
    bit         uns;
    logic [3:0] xv;
    logic [3:0] yv;
    logic [7:0] p;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Edges counted from the accepting edge up to the one that raises done
  function automatic int lat_of(input logic [3:0] xv, input logic [3:0] yv);
`ifdef MULTS4_EARLY_EXIT_EN
    return 2 + int'(xv[3]) + int'(yv[3]) + int'(xv[3] & yv[3]);
`else
    return 5;
`endif
  endfunction

  task automatic do_op(input bit uns, input logic [3:0] xv, input logic [3:0] yv,
                       output logic [7:0] p, output int lat, output int bc);
    @(negedge clk);
    x = xv;
    y = yv;
    if (uns) start_u = 1'b1; else start_s = 1'b1;
    @(posedge clk);
    lat = 1;
    bc  = 0;
    p   = 8'h00;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      start_s = 1'b0;
      start_u = 1'b0;
      if (uns ? done_u : done_s) begin
        p = uns ? prod_u : prod_s;
        break;
      end
      if (uns ? busy_u : busy_s) bc++;
      @(posedge clk);
      lat++;
    end
  endtask

  logic [7:0] p, p1, p2;
  int lat, bc, t1, t2, xs, ys;

  initial begin
    vecs[0] = '{1'b0, 4'h3, 4'h2, 8'h06};
    vecs[1] = '{1'b0, 4'h8, 4'h8, 8'h40};
    vecs[2] = '{1'b0, 4'hF, 4'h7, 8'hF9};
    vecs[3] = '{1'b0, 4'h8, 4'h7, 8'hC8};
    vecs[4] = '{1'b0, 4'h0, 4'hF, 8'h00};
    vecs[5] = '{1'b0, 4'hE, 4'h3, 8'hFA};
    vecs[6] = '{1'b0, 4'h5, 4'h5, 8'h19};
    vecs[7] = '{1'b1, 4'hF, 4'hF, 8'hE1};
    vecs[8] = '{1'b1, 4'h8, 4'h8, 8'h40};
    vecs[9] = '{1'b1, 4'h7, 4'h3, 8'h15};

    reset = 1'b1; start_s = 1'b0; start_u = 1'b0; x = 4'h0; y = 4'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy_s", busy_s, 0);
    chk("rst_done_s", done_s, 0);
    chk("rst_prod_s", prod_s, 0);
    chk("rst_prod_u", prod_u, 0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].uns, vecs[i].xv, vecs[i].yv, p, lat, bc);
      chk($sformatf("vec%0d_prod", i), p, vecs[i].p);
      chk($sformatf("vec%0d_lat", i), lat, lat_of(vecs[i].xv, vecs[i].yv));
      chk($sformatf("vec%0d_busy", i), bc, lat_of(vecs[i].xv, vecs[i].yv) - 1);
    end

    // back-to-back with start held high
    @(negedge clk);
    x = 4'hE; y = 4'h3; start_s = 1'b1;
    @(posedge clk);
    @(negedge clk);
    x = 4'h5; y = 4'h5;
    t1 = -1; t2 = -1; p1 = 8'h00; p2 = 8'h00;
    for (int c = 1; c <= 20; c++) begin
      if (done_s) begin
        if (t1 < 0) begin
          t1 = c; p1 = prod_s;
        end else if (t2 < 0) begin
          t2 = c; p2 = prod_s; start_s = 1'b0;
        end
      end
      @(negedge clk);
    end
    start_s = 1'b0;
    chk("b2b_t1", t1, lat_of(4'hE, 4'h3));
    chk("b2b_p1", p1, 8'hFA);
    chk("b2b_gap", t2 - t1, lat_of(4'h5, 4'h5));
    chk("b2b_p2", p2, 8'h19);
    chk("b2b_idle", busy_s, 0);

    // start and operand changes while busy are ignored
    @(negedge clk);
    x = 4'hF; y = 4'hF; start_s = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_s = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start_s = 1'b1; x = 4'h0; y = 4'h0;
    @(negedge clk);
    start_s = 1'b0;
    t1 = 0;
    for (int c = 0; c < 10; c++) begin
      if (done_s) begin
        t1 = 1;
        break;
      end
      @(negedge clk);
    end
    chk("ign_done_seen", t1, 1);
    chk("ign_prod", prod_s, 8'h01);
    @(negedge clk);
    chk("ign_no_restart", busy_s, 0);

    // reset in P2 aborts
    x = 4'hF; y = 4'hF; start_s = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_s = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy_s, 0);
    chk("abort_done", done_s, 0);
    chk("abort_prod", prod_s, 0);
    reset = 1'b0;
    t1 = 0;
    repeat (5) begin
      @(negedge clk);
      if (done_s) t1++;
    end
    chk("abort_no_done", t1, 0);
    do_op(1'b0, 4'h3, 4'h2, p, lat, bc);
    chk("after_abort_prod", p, 8'h06);

    // exhaustive sweep against an integer reference
    for (int u = 0; u < 2; u++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          do_op(u[0], a[3:0], b[3:0], p, lat, bc);
          xs = (u == 0 && a >= 8) ? a - 16 : a;
          ys = (u == 0 && b >= 8) ? b - 16 : b;
          chk($sformatf("sweep_u%0d_%0h_%0h", u, a, b), p, (xs * ys) & 255);
          chk($sformatf("sweep_lat_u%0d_%0h_%0h", u, a, b), lat, lat_of(a[3:0], b[3:0]));
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
